// File: rtl/cdc_fifo_pkg.sv
// Shared CDC FIFO helpers: Gray/binary pointer conversion, pointer distance and fill compares.
// Used by both the write-side and the read-side controllers.
package cdc_fifo_pkg;

    localparam int PTR_MAX_W = 32;

    typedef logic [PTR_MAX_W-1:0] ptr_word_t;

    typedef enum logic {
        PRIO_P0 = 1'b0,
        PRIO_P1 = 1'b1
    } rr_prio_t;

    // Pointer width is always one bit wider than the address, so wrap can be told from empty.
    function automatic int ptr_width(input int addr_w);
        return addr_w + 1;
    endfunction

    function automatic ptr_word_t bin2gray(input ptr_word_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic ptr_word_t gray2bin(input ptr_word_t g);
        ptr_word_t b;
        b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic ptr_word_t ptr_distance(input ptr_word_t wr, input ptr_word_t rd,
                                               input int ptr_w);
        ptr_word_t mask;
        mask = (ptr_word_t'(1) << ptr_w) - ptr_word_t'(1);
        return (wr - rd) & mask;
    endfunction

    function automatic logic fill_is_full(input ptr_word_t fill, input int addr_w);
        return fill == (ptr_word_t'(1) << addr_w);
    endfunction

    function automatic logic fill_at_least(input ptr_word_t fill, input int thresh);
        return fill >= ptr_word_t'(thresh);
    endfunction

endpackage

// File: rtl/cdc_rr_arb2.sv
// Two-way round-robin arbiter; priority moves away from the holder only after the holder
// completes a transfer.
module cdc_rr_arb2
    import cdc_fifo_pkg::*;
(
    input  logic       i_a_clk,
    input  logic       i_a_rst,
    input  logic [1:0] i_valid,
    input  logic       i_xfer,
    output logic [1:0] o_grant
);

    rr_prio_t   r_prio;
    rr_prio_t   w_prio_next;
    logic [1:0] w_grant;
    logic [1:0] w_holder;

    assign w_holder = (r_prio == PRIO_P0) ? 2'b01 : 2'b10;

    always_ff @(posedge i_a_clk) begin
        if (i_a_rst) begin
            r_prio <= PRIO_P0;
        end else begin
            r_prio <= w_prio_next;
        end
    end

    always_comb begin
        w_grant = 2'b00;
        case (i_valid)
            2'b01:   w_grant = 2'b01;
            2'b10:   w_grant = 2'b10;
            2'b11:   w_grant = w_holder;
            default: w_grant = 2'b00;
        endcase
    end

    // A transfer by the non-holder (sole requester) leaves priority where it was.
    always_comb begin
        w_prio_next = r_prio;
        if (i_xfer && ((w_grant & w_holder) != 2'b00)) begin
            w_prio_next = (r_prio == PRIO_P0) ? PRIO_P1 : PRIO_P0;
        end
    end

    assign o_grant = w_grant;

endmodule

// File: rtl/cdc_fifo_wr_ctrl.sv
// Write-side CDC FIFO controller: arbitrates two producers, drives the memory write port and
// publishes the Gray write pointer. Optional almost_full output under CDC_WR_ALMOST_FULL_EN.
module cdc_fifo_wr_ctrl
    import cdc_fifo_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
`ifdef CDC_WR_ALMOST_FULL_EN
    parameter int AF_THRESH = 6,
`endif
    localparam int PTR_W = ptr_width(ADDR_W)
)
(
    input  logic              i_a_clk,
    input  logic              i_a_rst,
    input  logic              i_req0_valid,
    input  logic [DATA_W-1:0] i_req0_data,
    output logic              o_req0_ready,
    input  logic              i_req1_valid,
    input  logic [DATA_W-1:0] i_req1_data,
    output logic              o_req1_ready,
    input  logic [PTR_W-1:0]  i_rd_ptr_gray_sync,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_waddr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic [PTR_W-1:0]  o_wr_ptr_gray,
    output logic              o_full,
    output logic [PTR_W-1:0]  o_fill_level
`ifdef CDC_WR_ALMOST_FULL_EN
    ,
    output logic              o_almost_full
`endif
);

    logic [1:0]        w_valid;
    logic [1:0]        w_grant;
    logic [1:0]        w_ready;
    logic              w_xfer;
    logic              w_sel1;
    logic [PTR_W-1:0]  w_rd_bin;
    logic [PTR_W-1:0]  w_wr_bin_next;
    logic [PTR_W-1:0]  w_fill_next;
    logic              w_full_next;

    logic [PTR_W-1:0]  r_wr_bin;
    logic [PTR_W-1:0]  r_wr_gray;
    logic [PTR_W-1:0]  r_fill;
    logic              r_full;
    logic              r_pend_we;
    logic [ADDR_W-1:0] r_pend_addr;
    logic [DATA_W-1:0] r_pend_data;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_waddr;
    logic [DATA_W-1:0] r_mem_wdata;

    assign w_valid = {i_req1_valid, i_req0_valid};

    cdc_rr_arb2 u_arb (
        .i_a_clk (i_a_clk),
        .i_a_rst (i_a_rst),
        .i_valid (w_valid),
        .i_xfer  (w_xfer),
        .o_grant (w_grant)
    );

    // Readiness is masked by reset so nothing is accepted on the edge reset is sampled.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ready
            assign w_ready[gi] = w_grant[gi] & ~r_full & ~i_a_rst;
        end
    endgenerate

    assign o_req0_ready = w_ready[0];
    assign o_req1_ready = w_ready[1];

    assign w_xfer = |(w_valid & w_ready);
    assign w_sel1 = i_req1_valid & w_ready[1];

    assign w_rd_bin      = PTR_W'(gray2bin(ptr_word_t'(i_rd_ptr_gray_sync)));
    assign w_wr_bin_next = r_wr_bin + PTR_W'(w_xfer);
    assign w_fill_next   = PTR_W'(ptr_distance(ptr_word_t'(w_wr_bin_next),
                                               ptr_word_t'(w_rd_bin), PTR_W));
    assign w_full_next   = fill_is_full(ptr_word_t'(w_fill_next), ADDR_W);

    // Accepted word is staged one edge, then written together with the pointer publish.
    always_ff @(posedge i_a_clk) begin
        if (i_a_rst) begin
            r_wr_bin    <= '0;
            r_wr_gray   <= '0;
            r_fill      <= '0;
            r_full      <= 1'b0;
            r_pend_we   <= 1'b0;
            r_pend_addr <= '0;
            r_pend_data <= '0;
            r_mem_we    <= 1'b0;
            r_mem_waddr <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_wr_bin  <= w_wr_bin_next;
            r_fill    <= w_fill_next;
            r_full    <= w_full_next;
            r_pend_we <= w_xfer;
            if (w_xfer) begin
                r_pend_addr <= r_wr_bin[ADDR_W-1:0];
                r_pend_data <= w_sel1 ? i_req1_data : i_req0_data;
            end
            r_mem_we <= r_pend_we;
            if (r_pend_we) begin
                r_mem_waddr <= r_pend_addr;
                r_mem_wdata <= r_pend_data;
            end
            r_wr_gray <= PTR_W'(bin2gray(ptr_word_t'(r_wr_bin)));
        end
    end

    assign o_mem_we      = r_mem_we;
    assign o_mem_waddr   = r_mem_waddr;
    assign o_mem_wdata   = r_mem_wdata;
    assign o_wr_ptr_gray = r_wr_gray;
    assign o_full        = r_full;
    assign o_fill_level  = r_fill;

`ifdef CDC_WR_ALMOST_FULL_EN
    logic r_almost_full;

    always_ff @(posedge i_a_clk) begin
        if (i_a_rst) begin
            r_almost_full <= 1'b0;
        end else begin
            r_almost_full <= fill_at_least(ptr_word_t'(w_fill_next), AF_THRESH);
        end
    end

    assign o_almost_full = r_almost_full;
`endif

endmodule

// File: tb/tb_cdc_fifo_wr_ctrl.sv
// Randomized and directed bench for cdc_fifo_wr_ctrl against a queue-based reference model.
module tb_cdc_fifo_wr_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       v0, v1;
    logic [7:0] d0, d1;
    logic [3:0] rdg;

    logic       o_req0_ready, o_req1_ready;
    logic       o_mem_we;
    logic [2:0] o_mem_waddr;
    logic [7:0] o_mem_wdata;
    logic [3:0] o_wr_ptr_gray;
    logic       o_full;
    logic [3:0] o_fill_level;
`ifdef CDC_WR_ALMOST_FULL_EN
    logic       o_almost_full;
`endif

    always #5 clk = ~clk;

    cdc_fifo_wr_ctrl dut (
        .i_a_clk            (clk),
        .i_a_rst            (rst),
        .i_req0_valid       (v0),
        .i_req0_data        (d0),
        .o_req0_ready       (o_req0_ready),
        .i_req1_valid       (v1),
        .i_req1_data        (d1),
        .o_req1_ready       (o_req1_ready),
        .i_rd_ptr_gray_sync (rdg),
        .o_mem_we           (o_mem_we),
        .o_mem_waddr        (o_mem_waddr),
        .o_mem_wdata        (o_mem_wdata),
        .o_wr_ptr_gray      (o_wr_ptr_gray),
        .o_full             (o_full),
        .o_fill_level       (o_fill_level)
`ifdef CDC_WR_ALMOST_FULL_EN
        ,
        .o_almost_full      (o_almost_full)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: counts of accepted words, reader position, priority holder,
    // and a queue of accepted words still to appear on the memory port.
    int         m_wr = 0;
    int         m_rd = 0;
    int         m_fill = 0;
    bit         m_full = 0;
    bit         m_prio = 0;
    bit         m_pend_we = 0;
    int         m_pend_addr = 0;
    logic [7:0] acc_q[$];
    logic [7:0] wlog[$];
    bit         last_acc0 = 0, last_acc1 = 0;
    logic [3:0] prev_gray = 4'b0000;
    bit         saw_wrap = 0;

    function automatic int gray4(input int b);
        return (b ^ (b >> 1)) & 15;
    endfunction

    task automatic cycle();
        bit g0, g1, r0, r1, a0, a1, exp_we;
        int exp_addr, exp_gray;
        logic [7:0] exp_data;
        g0 = v0 && (!v1 || m_prio == 0);
        g1 = v1 && (!v0 || m_prio == 1);
        r0 = !rst && g0 && !m_full;
        r1 = !rst && g1 && !m_full;
        #1;
        check("req0_ready", 32'(o_req0_ready), 32'(r0));
        check("req1_ready", 32'(o_req1_ready), 32'(r1));
        a0 = v0 && r0;
        a1 = v1 && r1;
        @(posedge clk);
        #1;
        if (rst) begin
            m_wr = 0; m_fill = 0; m_full = 0; m_prio = 0; m_pend_we = 0;
            acc_q.delete();
            check("rst_mem_we", 32'(o_mem_we), 32'd0);
            check("rst_waddr", 32'(o_mem_waddr), 32'd0);
            check("rst_wdata", 32'(o_mem_wdata), 32'd0);
            check("rst_gray", 32'(o_wr_ptr_gray), 32'd0);
            check("rst_full", 32'(o_full), 32'd0);
            check("rst_fill", 32'(o_fill_level), 32'd0);
`ifdef CDC_WR_ALMOST_FULL_EN
            check("rst_af", 32'(o_almost_full), 32'd0);
`endif
        end else begin
            exp_we   = m_pend_we;
            exp_addr = m_pend_addr;
            exp_gray = gray4(m_wr);
            if (a0 || a1) begin
                acc_q.push_back(a0 ? d0 : d1);
                m_pend_addr = m_wr % 8;
                if ((a0 && m_prio == 0) || (a1 && m_prio == 1)) m_prio = !m_prio;
                m_wr = (m_wr + 1) % 16;
            end
            m_pend_we = a0 || a1;
            m_fill = (m_wr - m_rd + 16) % 16;
            m_full = (m_fill == 8);
            check("mem_we", 32'(o_mem_we), 32'(exp_we));
            if (exp_we) begin
                check("mem_waddr", 32'(o_mem_waddr), 32'(exp_addr));
                if (acc_q.size() == 0) begin
                    check("model_queue", 32'd0, 32'd1);
                end else begin
                    exp_data = acc_q.pop_front();
                    check("mem_wdata", 32'(o_mem_wdata), 32'(exp_data));
                end
                wlog.push_back(o_mem_wdata);
            end
            check("wr_ptr_gray", 32'(o_wr_ptr_gray), 32'(exp_gray));
            check("full", 32'(o_full), 32'(m_full));
            check("fill_level", 32'(o_fill_level), 32'(m_fill));
`ifdef CDC_WR_ALMOST_FULL_EN
            check("almost_full", 32'(o_almost_full), 32'(m_fill >= 6));
`endif
            if (prev_gray == 4'b1000 && o_wr_ptr_gray == 4'b0000) saw_wrap = 1;
        end
        prev_gray = o_wr_ptr_gray;
        last_acc0 = a0;
        last_acc1 = a1;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1; v0 = 0; v1 = 0; m_rd = 0; rdg = 4'b0000;
        cycle();
        rst = 0;
    endtask

    task automatic drive_random();
        if (!v0 || last_acc0) begin
            v0 = ($urandom % 100) < 70;
            d0 = 8'($urandom);
        end
        if (!v1 || last_acc1) begin
            v1 = ($urandom % 100) < 60;
            d1 = 8'($urandom);
        end
        if (m_fill > 0 && ($urandom % 4) != 0) m_rd = (m_rd + 1) % 16;
        rdg = 4'(gray4(m_rd));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int accepted;
        rst = 1; v0 = 1; v1 = 1; d0 = 8'h55; d1 = 8'h66; rdg = 4'b0000;
        @(negedge clk);
        repeat (2) cycle();
        rst = 0;

        // Single producer fills the FIFO.
        v1 = 0; v0 = 1; d0 = 8'hA1;
        repeat (11) begin
            cycle();
            if (last_acc0) d0 = d0 + 8'd1;
        end
        check("sp_gray", 32'(o_wr_ptr_gray), 32'b1100);
        check("sp_full", 32'(o_full), 32'd1);
        check("sp_fill", 32'(o_fill_level), 32'd8);
        check("sp_ready0", 32'(o_req0_ready), 32'd0);

        // Reader advances by one: full drops, one more word goes to address 0.
        m_rd = 1; rdg = 4'b0001;
        cycle();
        check("rel_full", 32'(o_full), 32'd0);
        check("rel_fill", 32'(o_fill_level), 32'd7);
        cycle();
        check("rel_acc", 32'(last_acc0), 32'd1);
        v0 = 0;
        cycle();
        check("rel_waddr", 32'(o_mem_waddr), 32'd0);
        check("rel_wdata", 32'(o_mem_wdata), 32'hA9);
        check("rel_gray", 32'(o_wr_ptr_gray), 32'b1101);

        // Contention: writes must alternate starting with producer 0.
        do_reset();
        v0 = 1; v1 = 1; d0 = 8'h00; d1 = 8'h10;
        wlog.delete();
        repeat (12) begin
            m_rd = m_wr; rdg = 4'(gray4(m_rd));
            cycle();
            if (last_acc0) d0 = d0 + 8'd1;
            if (last_acc1) d1 = d1 + 8'd1;
        end
        check("cont_count", 32'(wlog.size() >= 6), 32'd1);
        for (int i = 0; i < 6 && i < wlog.size(); i++) begin
            check("cont_order", 32'(wlog[i]), 32'((i % 2 == 0) ? (i / 2) : (8'h10 + i / 2)));
        end

        // Random traffic with a tracking reader; pointer must wrap at least once.
        do_reset();
        saw_wrap = 0; accepted = 0;
        repeat (300) begin
            drive_random();
            cycle();
            if (last_acc0 || last_acc1) accepted++;
        end
        v0 = 0; v1 = 0;
        repeat (3) cycle();
        check("wrap_seen", 32'(saw_wrap), 32'd1);
        check("wrap_words", 32'(accepted >= 20), 32'd1);

        // Reset in the cycle after a handshake squashes the pending write.
        do_reset();
        v0 = 1; d0 = 8'h77;
        cycle();
        check("mid_acc", 32'(last_acc0), 32'd1);
        v0 = 0; rst = 1; m_rd = 0; rdg = 4'b0000;
        cycle();
        rst = 0;
        cycle();
        check("mid_mem_we", 32'(o_mem_we), 32'd0);
        check("mid_gray", 32'(o_wr_ptr_gray), 32'd0);

        // Fill to six, then let the reader take one.
        v0 = 1; d0 = 8'hC0; accepted = 0;
        for (int i = 0; i < 12 && accepted < 6; i++) begin
            cycle();
            if (last_acc0) begin
                accepted++;
                d0 = d0 + 8'd1;
            end
        end
        v0 = 0;
        cycle();
        check("af_fill6", 32'(o_fill_level), 32'd6);
`ifdef CDC_WR_ALMOST_FULL_EN
        check("af_set", 32'(o_almost_full), 32'd1);
`endif
        m_rd = 1; rdg = 4'b0001;
        cycle();
        check("af_fill5", 32'(o_fill_level), 32'd5);
`ifdef CDC_WR_ALMOST_FULL_EN
        check("af_clear", 32'(o_almost_full), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
